// File: rtl/reg_file.sv
// rtl/reg_file.sv - 16x8 register file with pair pointer stepping and {N,Z,C} flags
// Two async read ports, one write-back port, 16-bit pair inc/dec and a masked flag register.
module reg_file #(
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  sel_a,
  input  logic [3:0]  sel_b,
  output logic [7:0]  data_a,
  output logic [7:0]  data_b,
  input  logic        wr_en,
  input  logic [3:0]  wr_sel,
  input  logic [7:0]  wr_data,
  input  logic [2:0]  pair_sel,
  input  logic [1:0]  pair_op,
  output logic [15:0] pair_out,
  input  logic [2:0]  flag_we,
  input  logic        c_in,
  input  logic        z_in,
  input  logic        n_in,
  input  logic        flags_load,
  input  logic [2:0]  flags_in,
  output logic        c_flag,
  output logic        z_flag,
  output logic        n_flag
);

  localparam logic [1:0] PAIR_INC = 2'b01;
  localparam logic [1:0] PAIR_DEC = 2'b10;

  logic [7:0]  r_regs [16];
  logic [2:0]  r_flags;

  logic [7:0]  w_regs_next [16];
  logic [2:0]  w_flags_next;
  logic [3:0]  w_lo_idx;
  logic [3:0]  w_hi_idx;
  logic [15:0] w_pair_cur;
  logic [15:0] w_pair_step;
  logic        w_pair_en;

  assign w_lo_idx   = {pair_sel, 1'b0};
  assign w_hi_idx   = {pair_sel, 1'b1};
  assign w_pair_cur = {r_regs[w_hi_idx], r_regs[w_lo_idx]};

  // 16-bit add/sub gives lo->hi carry/borrow and the FFFF/0000 wrap for free.
  always_comb begin
    w_pair_step = w_pair_cur;
    w_pair_en   = 1'b0;
    case (pair_op)
      PAIR_INC: begin
        w_pair_step = w_pair_cur + 16'd1;
        w_pair_en   = 1'b1;
      end
      PAIR_DEC: begin
        w_pair_step = w_pair_cur - 16'd1;
        w_pair_en   = 1'b1;
      end
      default: begin
        w_pair_step = w_pair_cur;
        w_pair_en   = 1'b0;
      end
    endcase
  end

  // Write-back is applied after the pair step so it wins on a shared byte.
  always_comb begin
    w_regs_next = r_regs;
    if (w_pair_en) begin
      w_regs_next[w_hi_idx] = w_pair_step[15:8];
      w_regs_next[w_lo_idx] = w_pair_step[7:0];
    end
    if (wr_en) begin
      w_regs_next[wr_sel] = wr_data;
    end
  end

  always_comb begin
    w_flags_next = r_flags;
    if (flags_load) begin
      w_flags_next = flags_in;
    end else begin
      if (flag_we[2]) w_flags_next[2] = n_in;
      if (flag_we[1]) w_flags_next[1] = z_in;
      if (flag_we[0]) w_flags_next[0] = c_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        r_regs[i] <= RESET_VALUE;
      end
      r_flags <= 3'b000;
    end else begin
      r_regs  <= w_regs_next;
      r_flags <= w_flags_next;
    end
  end

  assign data_a   = r_regs[sel_a];
  assign data_b   = r_regs[sel_b];
  assign pair_out = w_pair_cur;
  assign n_flag   = r_flags[2];
  assign z_flag   = r_flags[1];
  assign c_flag   = r_flags[0];

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - scoreboard testbench for reg_file
// Stimulus pushes expected outputs into a queue; a negedge monitor pops and compares.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [3:0]  sel_a, sel_b;
  logic [7:0]  data_a, data_b;
  logic        wr_en;
  logic [3:0]  wr_sel;
  logic [7:0]  wr_data;
  logic [2:0]  pair_sel;
  logic [1:0]  pair_op;
  logic [15:0] pair_out;
  logic [2:0]  flag_we;
  logic        c_in, z_in, n_in;
  logic        flags_load;
  logic [2:0]  flags_in;
  logic        c_flag, z_flag, n_flag;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    logic [2:0]  f;
  } exp_t;

  exp_t exp_q [$];

  // Reference state: plain byte array plus a 3-bit {N,Z,C} value.
  logic [7:0] m_reg [16];
  logic [2:0] m_flags;

  reg_file #(.RESET_VALUE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .sel_a(sel_a), .sel_b(sel_b), .data_a(data_a), .data_b(data_b),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .pair_sel(pair_sel), .pair_op(pair_op), .pair_out(pair_out),
    .flag_we(flag_we), .c_in(c_in), .z_in(z_in), .n_in(n_in),
    .flags_load(flags_load), .flags_in(flags_in),
    .c_flag(c_flag), .z_flag(z_flag), .n_flag(n_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
    m_flags = 3'b000;
  endtask

  task automatic step(input logic [3:0] sa, input logic [3:0] sb,
                      input logic we, input logic [3:0] ws, input logic [7:0] wd,
                      input logic [2:0] ps, input logic [1:0] po,
                      input logic [2:0] fwe, input logic ci, input logic zi, input logic ni,
                      input logic fl, input logic [2:0] fi);
    exp_t e;
    int lo;
    logic [15:0] p;
    @(posedge clk);
    #1;
    sel_a = sa; sel_b = sb; wr_en = we; wr_sel = ws; wr_data = wd;
    pair_sel = ps; pair_op = po; flag_we = fwe; c_in = ci; z_in = zi; n_in = ni;
    flags_load = fl; flags_in = fi;
    lo = int'(ps) * 2;
    e.a = m_reg[sa];
    e.b = m_reg[sb];
    e.p = {m_reg[lo + 1], m_reg[lo]};
    e.f = m_flags;
    exp_q.push_back(e);
    p = {m_reg[lo + 1], m_reg[lo]};
    if (po == 2'b01) p = p + 16'd1;
    else if (po == 2'b10) p = p - 16'd1;
    m_reg[lo + 1] = p[15:8];
    m_reg[lo]     = p[7:0];
    if (we) m_reg[ws] = wd;
    if (fl) m_flags = fi;
    else begin
      if (fwe[2]) m_flags[2] = ni;
      if (fwe[1]) m_flags[1] = zi;
      if (fwe[0]) m_flags[0] = ci;
    end
  endtask

  task automatic idle(input logic [3:0] sa, input logic [3:0] sb, input logic [2:0] ps);
    step(sa, sb, 1'b0, 4'd0, 8'h00, ps, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic write(input logic [3:0] ws, input logic [7:0] wd);
    step(ws, 4'd0, 1'b1, ws, wd, 3'd0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("data_a", {8'h00, data_a}, {8'h00, e.a});
        check("data_b", {8'h00, data_b}, {8'h00, e.b});
        check("pair_out", pair_out, e.p);
        check("flags", {13'd0, n_flag, z_flag, c_flag}, {13'd0, e.f});
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst_n = 1'b1;
    sel_a = 4'd0; sel_b = 4'd0; wr_en = 1'b0; wr_sel = 4'd0; wr_data = 8'h00;
    pair_sel = 3'd0; pair_op = 2'b00; flag_we = 3'b000;
    c_in = 1'b0; z_in = 1'b0; n_in = 1'b0; flags_load = 1'b0; flags_in = 3'b000;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    check("reset_data_a", {8'h00, data_a}, 16'h0000);
    check("reset_flags", {13'd0, n_flag, z_flag, c_flag}, 16'h0000);
    #9 rst_n = 1'b1;

    for (int k = 0; k < 8; k++) idle(4'd3, 4'd9, 3'(k));

    step(4'd5, 4'd0, 1'b1, 4'd5, 8'hA7, 3'd0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    idle(4'd5, 4'd0, 3'd0);

    write(4'd2, 8'hFF);
    write(4'd3, 8'h00);
    step(4'd2, 4'd3, 1'b0, 4'd0, 8'h00, 3'd1, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    idle(4'd2, 4'd3, 3'd1);
    write(4'd3, 8'hFF);
    write(4'd2, 8'hFF);
    step(4'd2, 4'd3, 1'b0, 4'd0, 8'h00, 3'd1, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    step(4'd2, 4'd3, 1'b0, 4'd0, 8'h00, 3'd1, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    idle(4'd2, 4'd3, 3'd1);
    check("wrap_model", {m_reg[3], m_reg[2]}, 16'hFFFF);

    write(4'd4, 8'hFF);
    write(4'd5, 8'h12);
    step(4'd5, 4'd4, 1'b1, 4'd4, 8'h55, 3'd2, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    idle(4'd5, 4'd4, 3'd2);
    check("pair_write_model", {m_reg[5], m_reg[4]}, 16'h1355);

    step(4'd0, 4'd0, 1'b0, 4'd0, 8'h00, 3'd0, 2'b00, 3'b101, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
    step(4'd0, 4'd0, 1'b0, 4'd0, 8'h00, 3'd0, 2'b00, 3'b111, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010);
    idle(4'd0, 4'd0, 3'd0);
    check("flag_model", {13'd0, m_flags}, 16'h0002);

    for (int n = 0; n < 400; n++) begin
      step(4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 8'($urandom),
           3'($urandom), 2'($urandom), 3'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 7) == 0), 3'($urandom));
    end
    idle(4'd0, 4'd0, 3'd0);

    // Async reset pulsed between edges while a write and pair step are pending.
    @(posedge clk);
    #1;
    wr_en = 1'b1; wr_sel = 4'd7; wr_data = 8'h3C; sel_a = 4'd7; sel_b = 4'd6;
    pair_sel = 3'd3; pair_op = 2'b01; flags_load = 1'b1; flags_in = 3'b111;
    #2 rst_n = 1'b0;
    #1;
    check("async_data_a", {8'h00, data_a}, 16'h0000);
    check("async_data_b", {8'h00, data_b}, 16'h0000);
    check("async_pair", pair_out, 16'h0000);
    check("async_flags", {13'd0, n_flag, z_flag, c_flag}, 16'h0000);
    wr_en = 1'b0; pair_op = 2'b00; flags_load = 1'b0;
    #1 rst_n = 1'b1;
    model_reset();
    idle(4'd7, 4'd6, 3'd3);
    idle(4'd7, 4'd6, 3'd3);

    repeat (3) @(posedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter RESET_VALUE, default 8'h00, the value loaded into every general register on reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have ports sel_a and sel_b, input, 4 bits each: read-port A/B register selects.
REQ-005 SHALL have ports data_a and data_b, output, 8 bits each: ALU operand A/B.
REQ-006 SHALL have ports wr_en (1 bit), wr_sel (4 bits) and wr_data (8 bits), input: ALU result write-back.
REQ-007 SHALL have port pair_sel, input, 3 bits: selects pair k = {r(2k+1), r(2k)}.
REQ-008 SHALL have port pair_op, input, 2 bits: 00 none, 01 increment, 10 decrement, 11 none.
REQ-009 SHALL have port pair_out, output, 16 bits: {r(2k+1), r(2k)} for the selected pair (memory pointer).
REQ-010 SHALL have port flag_we, input, 3 bits: per-flag update mask {N,Z,C}.
REQ-011 SHALL have ports c_in, z_in and n_in, input, 1 bit each: ALU cout, zout and nout.
REQ-012 SHALL have ports flags_load (1 bit) and flags_in (3 bits {N,Z,C}), input: bulk flag restore.
REQ-013 SHALL have ports c_flag, z_flag and n_flag, output, 1 bit each: registered flags; c_flag drives the ALU cin.

Function
REQ-014 SHALL hold 16 eight-bit registers r0..r15 and a 3-bit flag register {N,Z,C}.
REQ-015 SHALL drive data_a = r[sel_a], data_b = r[sel_b] and pair_out combinationally from current state.
REQ-016 SHALL provide no write-to-read bypass, so no combinational path exists from wr_data, c_in, z_in or n_in to any output.
REQ-017 SHALL, when wr_en=1, load wr_data into r[wr_sel] at the clock edge; the new value is visible the cycle after.
REQ-018 SHALL, for pair_op=01/10, set the selected pair to {hi,lo} +1 / -1 modulo 2^16 at the edge; lo carries/borrows into hi.
REQ-019 SHALL wrap FFFF+1 to 0000 and 0000-1 to FFFF, with no flag change from either.
REQ-020 SHALL, when wr_en targets a byte of the pair being stepped in the same cycle, give that byte wr_data and the other byte the pair-step result.
REQ-021 SHALL make pair_op and wr_en to disjoint registers in one cycle both take effect.
REQ-022 SHALL, when flags_load=1, set {N,Z,C} <= flags_in and ignore flag_we that cycle.
REQ-023 SHALL otherwise update each flag whose flag_we bit is 1 from its matching input, holding the flags whose bit is 0.
REQ-024 SHALL treat flag updates as independent of register writes; all may occur in one cycle.
REQ-025 SHALL leave all state unchanged for pair_op=11 with wr_en=0, flag_we=000 and flags_load=0.

Reset
REQ-026 SHALL, while rst_n=0, immediately and independently of clk force all registers to RESET_VALUE and all flags to 0; outputs follow combinationally.
REQ-027 SHALL let reset asserted mid-operation override any same-cycle write, pair step or flag load.
REQ-028 SHALL begin normal updates at the first rising clk edge after rst_n deasserts.

Verification
REQ-029 Scenario: reset then sel_a=3, sel_b=9 -> data_a=00, data_b=00, flags 000, pair_out=0000 for every pair_sel.
REQ-030 Scenario: wr_en=1, wr_sel=5, wr_data=A7, sel_a=5 -> data_a is old value that cycle and A7 the next cycle.
REQ-031 Scenario: r3:r2=00FF, pair_sel=1, pair_op=01 -> pair_out=0100; then r3:r2=FFFF with inc -> 0000; then dec -> FFFF.
REQ-032 Scenario: r5:r4=12FF, pair_sel=2, inc, same cycle wr_en=1, wr_sel=4, wr_data=55 -> r5=13, r4=55.
REQ-033 Scenario: flags 000, flag_we=101, c_in=1, z_in=1, n_in=1 -> N=1, Z=0, C=1; next flags_load=1, flags_in=010 with flag_we=111 -> flags 010.
REQ-034 Scenario: rst_n pulsed low between edges while wr_en=1 -> registers and flags read reset values before the next edge, and the write is lost.
